// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, the bit
// positions inside last_cause, counter width and parameter defaults.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_WAIT_LOCK,
        ST_HOLD,
        ST_RELEASE,
        ST_WAIT_ACK,
        ST_RUN
    } seq_state_e;

    // Bit positions inside last_cause = {lock_loss, ext, soft}
    localparam int CAUSE_SOFT = 0;
    localparam int CAUSE_EXT  = 1;
    localparam int CAUSE_LOCK = 2;
    localparam int CAUSE_W    = 3;

    // One down-counter serves both the hold phase and the ack timeout,
    // so it is sized for the largest ACK_TIMEOUT.
    localparam int CNT_W = 16;

    localparam int DEF_N_STAGES    = 4;
    localparam int DEF_HOLD_CYCLES = 16;
    localparam int DEF_ACK_TIMEOUT = 1024;

endpackage

// File: rtl/reset_sequencer_if.sv
// Bundle of the request inputs and status outputs of the reset sequencer.
//   master : board side, drives requests, lock and acks, observes status
//   slave  : the sequencer itself
interface reset_sequencer_if #(
    parameter int N_STAGES = reset_seq_pkg::DEF_N_STAGES
) ();
    logic                soft_rst_req;  // single-cycle soft reset pulse
    logic                ext_rst_req;   // level request, ipb_clk domain
    logic                pll_locked;    // asynchronous
    logic [N_STAGES-1:0] stage_ack;     // asynchronous, per stage
    logic [N_STAGES-1:0] stage_rst;     // active-high stage resets
    logic                busy;
    logic                seq_done;
    logic [N_STAGES-1:0] timeout_err;   // sticky
    logic [2:0]          last_cause;    // {lock_loss, ext, soft}
    logic [15:0]         seq_count;

    modport master (
        output soft_rst_req, ext_rst_req, pll_locked, stage_ack,
        input  stage_rst, busy, seq_done, timeout_err, last_cause, seq_count
    );

    modport slave (
        input  soft_rst_req, ext_rst_req, pll_locked, stage_ack,
        output stage_rst, busy, seq_done, timeout_err, last_cause, seq_count
    );
endinterface

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop synchronizer, WIDTH independent bits.
//   ipb_clk, ipb_rst_n : destination clock / async active-low reset
//   d                  : asynchronous inputs
//   q                  : synchronized outputs (reset to 0)
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             ipb_clk,
    input  logic             ipb_rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge ipb_clk or negedge ipb_rst_n) begin
        if (!ipb_rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all downstream stage resets until the PLL is locked,
// keeps them asserted for HOLD_CYCLES, then releases stages one at a time in
// ascending order, waiting for each stage's acknowledge (or a timeout) before
// releasing the next one.
//   ipb_clk, ipb_rst_n : clock, async active-low reset
//   bus (slave)        : requests, lock, acks in; stage resets and status out
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_STAGES    = DEF_N_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic               ipb_clk,
    input  logic               ipb_rst_n,
    reset_sequencer_if.slave   bus
);
    localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGES - 1);

    seq_state_e           state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [N_STAGES-1:0]  stage_rst_q;
    logic [N_STAGES-1:0]  timeout_err_q;
    logic                 busy_q;
    logic                 seq_done_q;
    logic [CAUSE_W-1:0]   last_cause_q;
    logic [15:0]          seq_count_q;
    logic                 pll_q;

    logic [N_STAGES:0]    sync_q;
    logic                 pll_s;
    logic [N_STAGES-1:0]  ack_s;
    logic                 lock_fall;
    logic [CAUSE_W-1:0]   cause_now;
    logic                 req;

    sync_2ff #(.WIDTH(N_STAGES + 1)) u_sync (
        .ipb_clk   (ipb_clk),
        .ipb_rst_n (ipb_rst_n),
        .d         ({bus.pll_locked, bus.stage_ack}),
        .q         (sync_q)
    );

    assign pll_s = sync_q[N_STAGES];
    assign ack_s = sync_q[N_STAGES-1:0];

    // Lock loss is the falling edge of the synchronized lock; while already
    // waiting for lock a low level is the normal condition, not a request.
    assign lock_fall = pll_q & ~pll_s;

    always_comb begin
        cause_now             = '0;
        cause_now[CAUSE_SOFT] = bus.soft_rst_req;
        cause_now[CAUSE_EXT]  = bus.ext_rst_req;
        cause_now[CAUSE_LOCK] = lock_fall;
    end

    assign req = |cause_now;

    always_ff @(posedge ipb_clk or negedge ipb_rst_n) begin
        if (!ipb_rst_n) begin
            state         <= ST_INIT;
            cnt           <= '0;
            idx           <= '0;
            stage_rst_q   <= '1;
            timeout_err_q <= '0;
            busy_q        <= 1'b1;
            seq_done_q    <= 1'b0;
            last_cause_q  <= '0;
            seq_count_q   <= '0;
            pll_q         <= 1'b0;
        end else begin
            seq_done_q <= 1'b0;
            pll_q      <= pll_s;
            if (req) begin
                // Any request restarts from the lock wait; a held ext request
                // keeps re-entering here, so the block parks in WAIT_LOCK.
                state        <= ST_WAIT_LOCK;
                stage_rst_q  <= '1;
                busy_q       <= 1'b1;
                last_cause_q <= cause_now;
                if (bus.soft_rst_req)
                    timeout_err_q <= '0;
            end else begin
                case (state)
                    ST_INIT: state <= ST_WAIT_LOCK;
                    ST_WAIT_LOCK: begin
                        if (pll_s) begin
                            cnt   <= CNT_W'(HOLD_CYCLES - 1);
                            state <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (cnt == '0) begin
                            idx   <= '0;
                            state <= ST_RELEASE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_RELEASE: begin
                        stage_rst_q[idx] <= 1'b0;
                        cnt              <= CNT_W'(ACK_TIMEOUT - 1);
                        state            <= ST_WAIT_ACK;
                    end
                    ST_WAIT_ACK: begin
                        if (ack_s[idx] || cnt == '0) begin
                            // A late stage is flagged but does not stall the rest.
                            if (!ack_s[idx])
                                timeout_err_q[idx] <= 1'b1;
                            if (idx == LAST_IDX) begin
                                state       <= ST_RUN;
                                busy_q      <= 1'b0;
                                seq_done_q  <= 1'b1;
                                seq_count_q <= seq_count_q + 1'b1;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= ST_RELEASE;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_RUN: ;
                    default: state <= ST_INIT;
                endcase
            end
        end
    end

    assign bus.stage_rst   = stage_rst_q;
    assign bus.busy        = busy_q;
    assign bus.seq_done    = seq_done_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.last_cause  = last_cause_q;
    assign bus.seq_count   = seq_count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer. Stimulus pushes the expected output snapshots
// (with the cycle they must appear on) into a queue; a monitor compares
// every change of the DUT outputs against the queue head.
module tb_reset_sequencer;

    logic ipb_clk   = 1'b0;
    logic ipb_rst_n = 1'b1;
    int   cyc       = 0;

    always #4 ipb_clk = ~ipb_clk;
    always @(posedge ipb_clk) cyc <= cyc + 1;

    reset_sequencer_if #(.N_STAGES(4)) bus ();

    reset_sequencer #(
        .N_STAGES    (4),
        .HOLD_CYCLES (16),
        .ACK_TIMEOUT (1024)
    ) dut (
        .ipb_clk   (ipb_clk),
        .ipb_rst_n (ipb_rst_n),
        .bus       (bus)
    );

    typedef struct packed {
        logic [3:0]  rst;
        logic        busy;
        logic        done;
        logic [3:0]  terr;
        logic [2:0]  cause;
        logic [15:0] cnt;
    } snap_t;

    typedef struct {
        snap_t s;
        int    at;    // expected cycle, -1 = any
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    logic [3:0] ack_mask = 4'hF;

    // Stage model: acknowledge 3 cycles after its reset is released.
    initial begin
        int ack_cnt [4];
        bus.stage_ack = '0;
        for (int k = 0; k < 4; k++) ack_cnt[k] = 0;
        forever begin
            @(negedge ipb_clk);
            for (int k = 0; k < 4; k++) begin
                if (bus.stage_rst[k] || !ack_mask[k]) begin
                    ack_cnt[k] = 0;
                    bus.stage_ack[k] = 1'b0;
                end else if (ack_cnt[k] < 3) begin
                    ack_cnt[k]++;
                    if (ack_cnt[k] == 3) bus.stage_ack[k] = 1'b1;
                end
            end
        end
    end

    // Monitor: every output change must match the next expected snapshot.
    initial begin
        snap_t prev, cur;
        exp_t  e;
        int    n;
        prev = 'x;
        n    = 0;
        forever begin
            @(negedge ipb_clk);
            cur = {bus.stage_rst, bus.busy, bus.seq_done, bus.timeout_err,
                   bus.last_cause, bus.seq_count};
            if (cur !== prev) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event @%0d: rst=%h busy=%b done=%b terr=%h cause=%b cnt=%0d",
                             cyc, cur.rst, cur.busy, cur.done, cur.terr, cur.cause, cur.cnt);
                end else begin
                    e = sb.pop_front();
                    if (cur !== e.s || (e.at >= 0 && cyc != e.at)) begin
                        errors++;
                        $display("FAIL event%0d: got rst=%h busy=%b done=%b terr=%h cause=%b cnt=%0d @%0d, need rst=%h busy=%b done=%b terr=%h cause=%b cnt=%0d @%0d",
                                 n, cur.rst, cur.busy, cur.done, cur.terr, cur.cause, cur.cnt, cyc,
                                 e.s.rst, e.s.busy, e.s.done, e.s.terr, e.s.cause, e.s.cnt, e.at);
                    end
                end
                n++;
            end
            prev = cur;
        end
    end

    task automatic tick();
        @(posedge ipb_clk);
        #1;
    endtask

    task automatic push(input logic [3:0] r, input logic b, input logic d,
                        input logic [3:0] t, input logic [2:0] c,
                        input logic [15:0] n, input int at);
        exp_t e;
        e.s.rst   = r;
        e.s.busy  = b;
        e.s.done  = d;
        e.s.terr  = t;
        e.s.cause = c;
        e.s.cnt   = n;
        e.at      = at;
        sb.push_back(e);
    endtask

    // Full release trail after HOLD is entered on cycle h, all acks returned.
    task automatic push_trail(input int h, input logic [3:0] t,
                              input logic [2:0] c, input logic [15:0] n);
        push(4'hE, 1, 0, t, c, n, h + 17);
        push(4'hC, 1, 0, t, c, n, h + 23);
        push(4'h8, 1, 0, t, c, n, h + 29);
        push(4'h0, 1, 0, t, c, n, h + 35);
        push(4'h0, 0, 1, t, c, n + 16'd1, h + 40);
        push(4'h0, 0, 0, t, c, n + 16'd1, h + 41);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: %0d expected events never seen", name, sb.size());
            sb.delete();
        end
    endtask

    // Async reset assertion, 3 cycles held, release; returns release cycle.
    task automatic do_reset(input logic pll, output int t0);
        tick();
        ipb_rst_n      = 1'b0;
        bus.pll_locked = pll;
        push(4'hF, 1, 0, 4'h0, 3'b000, 16'd0, -1);
        repeat (3) tick();
        ipb_rst_n = 1'b1;
        t0 = cyc;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d events pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, c, d, es, ee, n;
        bus.soft_rst_req = 1'b0;
        bus.ext_rst_req  = 1'b0;
        bus.pll_locked   = 1'b1;

        // Power-up: reset state, then a clean sequence with lock present
        push(4'hF, 1, 0, 4'h0, 3'b000, 16'd0, -1);
        #1 ipb_rst_n = 1'b0;
        repeat (3) tick();
        ipb_rst_n = 1'b1;
        t0 = cyc;
        push_trail(t0 + 3, 4'h0, 3'b000, 16'd0);
        drain("powerup");

        // No lock for 100 cycles: everything stays held
        do_reset(1'b0, t0);
        push_trail(t0 + 103, 4'h0, 3'b000, 16'd0);
        repeat (100) tick();
        bus.pll_locked = 1'b1;
        drain("late_lock");

        // Stage 2 never acknowledges: timeout flagged, stage 3 still released
        ack_mask = 4'b1011;
        do_reset(1'b1, t0);
        push(4'hE, 1, 0, 4'h0, 3'b000, 16'd0, t0 + 20);
        push(4'hC, 1, 0, 4'h0, 3'b000, 16'd0, t0 + 26);
        push(4'h8, 1, 0, 4'h0, 3'b000, 16'd0, t0 + 32);
        push(4'h8, 1, 0, 4'h4, 3'b000, 16'd0, t0 + 1056);
        push(4'h0, 1, 0, 4'h4, 3'b000, 16'd0, t0 + 1057);
        push(4'h0, 0, 1, 4'h4, 3'b000, 16'd1, t0 + 1062);
        push(4'h0, 0, 0, 4'h4, 3'b000, 16'd1, t0 + 1063);
        drain("timeout");
        ack_mask = 4'hF;

        // Soft request in RUN: clears timeout flag, count reaches 2
        tick();
        c = cyc;
        bus.soft_rst_req = 1'b1;
        es = c + 1;
        push(4'hF, 1, 0, 4'h0, 3'b001, 16'd1, es);
        push_trail(es + 1, 4'h0, 3'b001, 16'd1);
        tick();
        bus.soft_rst_req = 1'b0;
        drain("soft");

        // External request while waiting on stage 1's ack
        tick();
        c = cyc;
        bus.soft_rst_req = 1'b1;
        es = c + 1;
        push(4'hF, 1, 0, 4'h0, 3'b001, 16'd2, es);
        push(4'hE, 1, 0, 4'h0, 3'b001, 16'd2, es + 18);
        push(4'hC, 1, 0, 4'h0, 3'b001, 16'd2, es + 24);
        tick();
        bus.soft_rst_req = 1'b0;
        n = 0;
        while (bus.stage_rst !== 4'hC && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (bus.stage_rst !== 4'hC) begin
            errors++;
            $display("FAIL wait_stage1: stage_rst=%h, need C", bus.stage_rst);
        end
        tick();
        bus.ext_rst_req = 1'b1;
        ee = cyc + 1;
        push(4'hF, 1, 0, 4'h0, 3'b010, 16'd2, ee);
        push_trail(ee + 1, 4'h0, 3'b010, 16'd2);
        tick();
        bus.ext_rst_req = 1'b0;
        drain("ext");

        // Lock loss together with a soft request, then relock later
        tick();
        c = cyc;
        bus.pll_locked = 1'b0;
        tick();
        tick();
        bus.soft_rst_req = 1'b1;
        push(4'hF, 1, 0, 4'h0, 3'b101, 16'd3, c + 3);
        tick();
        bus.soft_rst_req = 1'b0;
        repeat (50) tick();
        checks++;
        if (bus.stage_rst !== 4'hF || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL lock_wait: stage_rst=%h busy=%b, need F 1", bus.stage_rst, bus.busy);
        end
        drain("lock_loss");
        c = cyc;
        bus.pll_locked = 1'b1;
        push_trail(c + 3, 4'h0, 3'b101, 16'd3);
        drain("relock");

        // Held external request parks the block until it drops
        tick();
        c = cyc;
        bus.ext_rst_req = 1'b1;
        push(4'hF, 1, 0, 4'h0, 3'b010, 16'd4, c + 1);
        repeat (30) tick();
        d = cyc;
        bus.ext_rst_req = 1'b0;
        push_trail(d + 1, 4'h0, 3'b010, 16'd4);
        drain("ext_held");

        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter N_STAGES, default 4: number of downstream reset stages, range 1..8.
REQ-002 Parameter HOLD_CYCLES, default 16: cycles all stage resets are held asserted, range 4..255.
REQ-003 Parameter ACK_TIMEOUT, default 1024: cycles to wait for a stage acknowledge, range 16..65535.
REQ-004 ipb_clk  in  1  sole clock (125 MHz IPbus clock).
REQ-005 ipb_rst_n  in  1  asynchronous active-low reset.
REQ-006 soft_rst_req  in  1  single-cycle IPbus soft-reset request pulse.
REQ-007 ext_rst_req  in  N_STAGES... no: in  1  level reset request from board logic, synchronous to ipb_clk.
REQ-008 pll_locked  in  1  clock-generator lock, asynchronous.
REQ-009 stage_ack  in  N_STAGES  per-stage "reset seen and released" level from the slow domains, asynchronous.
REQ-010 stage_rst  out  N_STAGES  active-high reset to each stage.
REQ-011 busy  out  1  high while the sequence runs.
REQ-012 seq_done  out  1  one-cycle pulse when the sequence completes.
REQ-013 timeout_err  out  N_STAGES  sticky per-stage timeout flags.
REQ-014 last_cause  out  3  {lock_loss, ext, soft} that started the latest sequence.
REQ-015 seq_count  out  16  number of completed sequences, wraps at 0xFFFF->0.

Function
REQ-016 pll_locked and each stage_ack bit shall pass a 2-flop synchronizer before use.
REQ-017 States: INIT, WAIT_LOCK, HOLD, RELEASE, WAIT_ACK, RUN.
REQ-018 INIT: all stage_rst=1, busy=1; next cycle -> WAIT_LOCK.
REQ-019 WAIT_LOCK: hold all resets until synchronized pll_locked=1, then load hold counter with HOLD_CYCLES-1 -> HOLD.
REQ-020 HOLD: decrement counter; at 0 set stage index i=0 -> RELEASE.
REQ-021 RELEASE: deassert stage_rst[i] (lower stages stay released), load timeout counter ACK_TIMEOUT-1 -> WAIT_ACK.
REQ-022 WAIT_ACK: on synchronized stage_ack[i]=1, or counter reaching 0 (also set timeout_err[i]), advance i; if i was N_STAGES-1 -> RUN, else -> RELEASE.
REQ-023 Entry to RUN: busy=0, seq_done pulses exactly one cycle, seq_count increments.
REQ-024 In RUN, soft_rst_req=1, ext_rst_req=1, or synchronized pll_locked falling shall set last_cause bits for every source active that cycle, assert all stage_rst on the next cycle, and go to WAIT_LOCK.
REQ-025 Any request in WAIT_LOCK/HOLD/RELEASE/WAIT_ACK shall restart the sequence: all stage_rst reasserted next cycle, state -> WAIT_LOCK, last_cause updated, seq_count unchanged.
REQ-026 ext_rst_req held high shall keep the block in WAIT_LOCK with all resets asserted until it drops.
REQ-027 Stage release order shall be strictly ascending index; stage_rst[k] never deasserts before stage_rst[k-1].
REQ-028 timeout_err bits shall clear only on ipb_rst_n or on the start of a soft-request-caused sequence.
REQ-029 All outputs shall be registered.

Reset
REQ-030 On ipb_rst_n=0: state=INIT, stage_rst all 1, busy=1, seq_done=0, timeout_err=0, last_cause=0, seq_count=0, synchronizers 0.
REQ-031 Deassertion of ipb_rst_n shall be synchronized externally; the block shall tolerate it mid-sequence by restarting from INIT.

Structure
REQ-032 State encoding, cause-bit indices and parameter defaults shall live in package reset_seq_pkg.
REQ-033 The 2-flop synchronizer shall be sub-module sync_2ff (parameterized width), instantiated once for {pll_locked, stage_ack}.

Verification
REQ-034 Reset release, pll_locked=1, acks returned 3 cycles after each release -> stage_rst 0xF->0xE->0xC->0x8->0x0, seq_done one pulse, seq_count=1.
REQ-035 pll_locked=0 for 100 cycles after reset -> stage_rst stays 0xF, busy=1 throughout; HOLD begins after lock+2 sync cycles.
REQ-036 stage_ack[2] never asserted -> timeout_err=0x4 after 1024 cycles in WAIT_ACK, stage 3 still released, seq_done pulses.
REQ-037 soft_rst_req pulse in RUN -> stage_rst=0xF next cycle, last_cause=3'b001, timeout_err cleared, seq_count=2 at completion.
REQ-038 ext_rst_req during WAIT_ACK for stage 1 -> stage_rst=0xF next cycle, last_cause=3'b010, seq_count not incremented until completion.
REQ-039 pll_locked drop in RUN with simultaneous soft_rst_req -> last_cause=3'b101, sequence waits in WAIT_LOCK until relock.
